// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant owner
// and wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} arb_gnt_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester always wins; on a contest the
// port that lost the previous contest wins, D first after reset.
module arb_rr2 import mem_arb_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output arb_gnt_t   gnt
);

    arb_gnt_t prio;

    // Pointer moves only when a contested grant is actually taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= GNT_D;
        end else if (update && req == 2'b11) begin
            prio <= (gnt == GNT_D) ? GNT_I : GNT_D;
        end
    end

    always_comb begin
        gnt = GNT_I;
        if (req == 2'b11) begin
            gnt = prio;
        end else if (req[1]) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D)
// ports; each access runs IDLE -> ISSUE -> WAIT(LATENCY) -> RESP.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              gnt_d
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    arb_gnt_t         pick;
    arb_gnt_t         owner;
    logic [CNT_W-1:0] cnt;
    logic             we_q;

    arb_rr2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({d_req, i_req}),
        .update (state == IDLE),
        .gnt    (pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_en    = (state == ISSUE);
        m_we    = (state == ISSUE) && we_q;
        i_ready = (state == RESP) && (owner == GNT_I);
        d_ready = (state == RESP) && (owner == GNT_D);
        gnt_d   = (owner == GNT_D);
    end

    // Request is latched in IDLE so the requester may drop it mid-access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= GNT_I;
            we_q    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            cnt     <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner <= pick;
                        if (pick == GNT_D) begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            we_q    <= d_we;
                        end else begin
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ISSUE: cnt <= CNT_W'(LATENCY - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner == GNT_I) begin
                            i_rdata <= m_rdata;
                        end else if (!we_q) begin
                            d_rdata <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal timing/data, plus LATENCY=1 and 15 builds.
module tb_mem_port_arbiter;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        reset, aux_reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_ready, d_ready, m_en, m_we, gnt_d;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    logic        aux_req;
    logic [31:0] aux_addr, aux_rdata;
    logic        a1_iready, a1_dready, a1_men, a1_mwe, a1_gnt;
    logic [31:0] a1_irdata, a1_drdata, a1_maddr, a1_mwdata;
    logic        a15_iready, a15_dready, a15_men, a15_mwe, a15_gnt;
    logic [31:0] a15_irdata, a15_drdata, a15_maddr, a15_mwdata;
    bit          aux_done = 0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .gnt_d(gnt_d)
    );

    mem_port_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_l1 (
        .clk(clk), .reset(aux_reset),
        .i_req(aux_req), .i_addr(aux_addr), .i_ready(a1_iready), .i_rdata(a1_irdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ready(a1_dready), .d_rdata(a1_drdata),
        .m_en(a1_men), .m_we(a1_mwe), .m_addr(a1_maddr), .m_wdata(a1_mwdata),
        .m_rdata(aux_rdata), .gnt_d(a1_gnt)
    );

    mem_port_arbiter #(.LATENCY(15), .ADDR_W(32), .DATA_W(32)) dut_l15 (
        .clk(clk), .reset(aux_reset),
        .i_req(aux_req), .i_addr(aux_addr), .i_ready(a15_iready), .i_rdata(a15_irdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ready(a15_dready), .d_rdata(a15_drdata),
        .m_en(a15_men), .m_we(a15_mwe), .m_addr(a15_maddr), .m_wdata(a15_mwdata),
        .m_rdata(aux_rdata), .gnt_d(a15_gnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit want_d, input int limit, output int at, output bit other);
        at = -1;
        other = 0;
        for (int k = 0; k < limit; k++) begin
            step();
            if (want_d ? i_ready : d_ready) other = 1;
            if (want_d ? d_ready : i_ready) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Memory contents; unwritten words read as a fixed function of the address.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] memval(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
    endfunction

    bit          md_active = 0, md_w_d = 0, md_we = 0, md_gnt_d = 0, md_pref_d = 1;
    int          md_s = 0;
    logic [31:0] md_addr = '0, md_wdata = '0, md_i_rd = '0, md_d_rd = '0;
    bit          mp_pend = 0;
    int          mp_cyc = 0;
    logic [31:0] mp_addr = '0;

    // Model: an access started in cycle s strobes memory at s+1, captures at
    // s+L+1, pulses ready at s+L+2 and frees the port for cycle s+L+3.
    always @(negedge clk) begin
        int       off;
        bit       w_d;
        logic [4:0] ectl;
        aux_rdata = 32'hC0DE_0000 | cyc;
        if (!reset) begin
            md_active = 0; md_gnt_d = 0; md_pref_d = 1; md_we = 0;
            md_addr = '0; md_wdata = '0; md_i_rd = '0; md_d_rd = '0;
            mp_pend = 0;
        end else begin
            off  = cyc - md_s;
            ectl = {md_active && off == 1, md_active && off == 1 && md_we,
                    md_active && off == int'(L) + 2 && !md_w_d,
                    md_active && off == int'(L) + 2 && md_w_d, md_gnt_d};
            check("model_ctl", {m_en, m_we, i_ready, d_ready, gnt_d}, ectl);
            check("model_m_addr", m_addr, md_addr);
            check("model_m_wdata", m_wdata, md_wdata);
            check("model_i_rdata", i_rdata, md_i_rd);
            check("model_d_rdata", d_rdata, md_d_rd);
            if (md_active && off == int'(L) + 1 && !md_we) begin
                if (md_w_d) md_d_rd = memval(md_addr);
                else        md_i_rd = memval(md_addr);
            end
            if (md_active && off == int'(L) + 2) begin
                md_active = 0;
            end else if (!md_active && (i_req || d_req)) begin
                if (i_req && d_req) begin
                    w_d = md_pref_d;
                    md_pref_d = !w_d;
                end else begin
                    w_d = d_req;
                end
                md_w_d = w_d; md_gnt_d = w_d; md_active = 1; md_s = cyc;
                md_addr  = w_d ? d_addr : i_addr;
                md_we    = w_d ? d_we : 1'b0;
                md_wdata = w_d ? d_wdata : 32'h0;
            end
            if (m_en) begin
                mp_pend = 1; mp_cyc = cyc; mp_addr = m_addr;
                if (m_we) mem[m_addr] = m_wdata;
            end
        end
        if (mp_pend && cyc == mp_cyc + int'(L)) begin
            m_rdata = memval(mp_addr);
            mp_pend = 0;
        end else begin
            m_rdata = 32'hBAD0_0000 ^ cyc;
        end
    end

    initial begin
        int c0, r1, r15, e1;
        @(posedge aux_reset);
        step();
        aux_addr = 32'h40; aux_req = 1'b1;
        c0 = cyc; r1 = -1; r15 = -1; e1 = -1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (a1_men && e1 < 0) e1 = cyc;
            if (a1_iready && r1 < 0) begin
                r1 = cyc;
                check("l1_rdata", a1_irdata, 32'hC0DE_0000 | (c0 + 2));
            end
            if (a15_iready && r15 < 0) begin
                r15 = cyc;
                check("l15_rdata", a15_irdata, 32'hC0DE_0000 | (c0 + 16));
                aux_req = 1'b0;
            end
        end
        check("l1_m_en_cycle", e1 - c0, 1);
        check("l1_ready_cycle", r1 - c0, 3);
        check("l15_ready_cycle", r15 - c0, 17);
        aux_done = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, at;
        bit oth;
        reset = 1'b0; aux_reset = 1'b0; aux_req = 1'b0; aux_addr = '0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem[32'h0] = 32'h2002_0005;
        repeat (3) step();
        check("reset_outputs", {m_en, m_we, i_ready, d_ready, gnt_d, m_addr, m_wdata}, '0);
        reset = 1'b1; aux_reset = 1'b1;
        step();

        // Store to 84
        d_req = 1; d_we = 1; d_addr = 84; d_wdata = 7; c0 = cyc;
        step();
        check("t1_issue", {m_en, m_we}, 2'b11);
        check("t1_m_addr", m_addr, 84);
        check("t1_m_wdata", m_wdata, 7);
        wait_ready(1, 10, at, oth);
        check("t1_d_ready_cycle", at - c0, 4);
        check("t1_no_i_ready", oth, 0);
        d_req = 0; d_we = 0;
        step();

        // Fetch from 0
        i_req = 1; i_addr = 0; c0 = cyc;
        wait_ready(0, 10, at, oth);
        check("t2_i_ready_cycle", at - c0, 4);
        check("t2_i_rdata", i_rdata, 32'h2002_0005);
        i_req = 0;
        step();

        // Both held from reset release: D, I, D, I
        reset = 0;
        i_req = 1; i_addr = 4; d_req = 1; d_we = 0; d_addr = 8;
        step(); step();
        reset = 1; c0 = cyc;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("t3_ready_pattern", {i_ready, d_ready},
                  {(k == 9 || k == 19) ? 1'b1 : 1'b0, (k == 4 || k == 14) ? 1'b1 : 1'b0});
            if (k == 19) begin
                i_req = 0; d_req = 0;
            end
        end
        check("t3_d_rdata", d_rdata, 32'h5A5A_0F07);
        check("t3_i_rdata", i_rdata, 32'h5A5A_0F0B);

        // Load from 80, D drops mid-access, I arrives during WAIT
        d_req = 1; d_we = 0; d_addr = 80; c0 = cyc;
        step(); step();
        d_req = 0; i_req = 1; i_addr = 12;
        wait_ready(1, 10, at, oth);
        check("t4_d_ready_cycle", at - c0, 4);
        check("t4_d_rdata", d_rdata, 32'h5A5A_0F5F);
        step(); step();
        check("t4_i_issue", {m_en, gnt_d, m_addr}, {1'b1, 1'b0, 32'd12});
        wait_ready(0, 10, at, oth);
        check("t4_i_ready_cycle", at - c0, 9);
        i_req = 0;
        step();

        // Contest won by D, reset during WAIT, D wins again after release
        i_req = 1; i_addr = 16; d_req = 1; d_we = 0; d_addr = 20;
        step();
        check("t5_first_gnt_d", gnt_d, 1);
        step();
        reset = 0;
        #1;
        check("t5_reset_ctl", {m_en, m_we, i_ready, d_ready, gnt_d}, 5'b0);
        check("t5_reset_data", {m_addr, m_wdata}, 64'h0);
        check("t5_reset_rdata", {i_rdata, d_rdata}, 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_no_ready_in_reset", {i_ready, d_ready}, 2'b00);
        end
        reset = 1; c0 = cyc;
        step();
        check("t5_post_reset_gnt", {m_en, gnt_d, m_addr}, {1'b1, 1'b1, 32'd20});
        wait_ready(1, 10, at, oth);
        check("t5_d_ready_cycle", at - c0, 4);
        check("t5_no_i_ready", oth, 0);
        i_req = 0; d_req = 0;
        repeat (3) step();

        for (int k = 0; k < 100 && !aux_done; k++) step();
        check("aux_done", aux_done, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
